// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity mode constants
// and the half-bit timer reload helper.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4,
    RX_WAIT_HIGH = 3'd5
  } uart_rx_state_t;

  localparam int unsigned UART_PARITY_EVEN = 0;
  localparam int unsigned UART_PARITY_ODD  = 1;

  // Timer load on the start edge so the first sample lands mid start bit.
  function automatic int unsigned uart_half_bit(input int unsigned cpb);
    return cpb / 2 - 1;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for asynchronous level inputs.
//   clk       : destination clock
//   rst_n     : asynchronous active-low reset, both flops load reset_val
//   async_in  : asynchronous input
//   sync_out  : synchronised output (two clk cycles of latency)
module uart_sync #(
  parameter int unsigned      width     = 1,
  parameter logic [width-1:0] reset_val = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] async_in,
  output logic [width-1:0] sync_out
);

  logic [width-1:0] meta_q;

  // First flop may go metastable; second flop gives it a cycle to resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q   <= reset_val;
      sync_out <= reset_val;
    end else begin
      meta_q   <= async_in;
      sync_out <= meta_q;
    end
  end

endmodule

// File: rtl/uart_rx_framed.sv
// Framed UART receiver with mid-bit sampling, start-glitch rejection,
// stop-bit framing check, optional parity check and a valid/ready output
// register with sticky overrun.
//
// Build option: define UART_RX_PARITY_EN to add one parity bit per frame
// (checked against parity_odd); otherwise out_parity_err stays 0.
//
// Ports:
//   ser_clk        : sole clock
//   rst_n          : asynchronous active-low reset
//   SER_TX         : asynchronous serial line, idles high
//   out_data       : received word (LSB first on the line)
//   out_valid      : out_data holds an unconsumed word
//   out_ready      : consumer accepts the word when out_valid && out_ready
//   out_frame_err  : held word's stop bit sampled low
//   out_parity_err : held word failed parity
//   out_overrun    : sticky, a word was dropped because the register was full
module uart_rx_framed
  import uart_pkg::*;
#(
  parameter int unsigned clocks_per_bit = 4,
  parameter int unsigned data_bits      = 8,
  parameter int unsigned parity_odd     = 0
) (
  input  logic                 ser_clk,
  input  logic                 rst_n,
  input  logic                 SER_TX,
  output logic [data_bits-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_frame_err,
  output logic                 out_parity_err,
  output logic                 out_overrun
);

  localparam int unsigned TIMER_W = $clog2(clocks_per_bit);
  localparam int unsigned CNT_W   = $clog2(data_bits + 1);

  localparam logic [TIMER_W-1:0] HALF_BIT = TIMER_W'(uart_half_bit(clocks_per_bit));
  localparam logic [TIMER_W-1:0] FULL_BIT = TIMER_W'(clocks_per_bit - 1);
  localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(data_bits - 1);

  logic rx;

  uart_rx_state_t       state_q,   state_d;
  logic [TIMER_W-1:0]   timer_q,   timer_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [data_bits-1:0] shift_q,   shift_d;

  logic [data_bits-1:0] out_data_d;
  logic                 out_valid_d;
  logic                 out_frame_err_d;
  logic                 out_parity_err_d;
  logic                 out_overrun_d;

  logic sample;
  logic handshake;

`ifdef UART_RX_PARITY_EN
  localparam logic ODD_PAR = (parity_odd == UART_PARITY_ODD);
  logic par_q,     par_d;
  logic par_err_q, par_err_d;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = (parity_odd == UART_PARITY_ODD);
`endif

  // Line idles high, so the synchroniser resets to 1 to avoid a false start.
  uart_sync #(
    .width     (1),
    .reset_val (1'b1)
  ) u_sync (
    .clk      (ser_clk),
    .rst_n    (rst_n),
    .async_in (SER_TX),
    .sync_out (rx)
  );

  assign sample    = (timer_q == '0);
  assign handshake = out_valid & out_ready;

  // State and datapath registers.
  always_ff @(posedge ser_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RX_IDLE;
      timer_q        <= '0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      out_data       <= '0;
      out_valid      <= 1'b0;
      out_frame_err  <= 1'b0;
      out_parity_err <= 1'b0;
      out_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q          <= 1'b0;
      par_err_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      out_data       <= out_data_d;
      out_valid      <= out_valid_d;
      out_frame_err  <= out_frame_err_d;
      out_parity_err <= out_parity_err_d;
      out_overrun    <= out_overrun_d;
`ifdef UART_RX_PARITY_EN
      par_q          <= par_d;
      par_err_q      <= par_err_d;
`endif
    end
  end

  // Next-state, bit sampling and output register update.
  always_comb begin
    state_d          = state_q;
    timer_d          = timer_q;
    bit_cnt_d        = bit_cnt_q;
    shift_d          = shift_q;
    out_data_d       = out_data;
    out_valid_d      = out_valid;
    out_frame_err_d  = out_frame_err;
    out_parity_err_d = out_parity_err;
    out_overrun_d    = out_overrun;
`ifdef UART_RX_PARITY_EN
    par_d            = par_q;
    par_err_d        = par_err_q;
`endif

    // A handshake frees the register; a delivery below may refill it.
    if (handshake) begin
      out_valid_d   = 1'b0;
      out_overrun_d = 1'b0;
    end

    // Bit timer only runs while a frame is being sampled.
    if (state_q inside {RX_START, RX_DATA, RX_PARITY, RX_STOP}) begin
      timer_d = sample ? FULL_BIT : timer_q - TIMER_W'(1);
    end

    case (state_q)
      RX_IDLE: begin
        if (!rx) begin
          state_d = RX_START;
          timer_d = HALF_BIT;
        end
      end

      RX_START: begin
        if (sample) begin
          // High at mid start bit means a glitch: drop silently.
          if (rx) begin
            state_d = RX_IDLE;
          end else begin
            state_d   = RX_DATA;
            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            par_d     = 1'b0;
`endif
          end
        end
      end

      RX_DATA: begin
        if (sample) begin
          shift_d   = {rx, shift_q[data_bits-1:1]};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
`ifdef UART_RX_PARITY_EN
          par_d     = par_q ^ rx;
`endif
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (sample) begin
          par_err_d = ((par_q ^ rx) != ODD_PAR);
          state_d   = RX_STOP;
        end
      end
`endif

      RX_STOP: begin
        if (sample) begin
          // Every word is delivered, framing errors included.
          if (!out_valid || out_ready) begin
            out_data_d      = shift_q;
            out_valid_d     = 1'b1;
            out_frame_err_d = ~rx;
`ifdef UART_RX_PARITY_EN
            out_parity_err_d = par_err_q;
`else
            out_parity_err_d = 1'b0;
`endif
          end else begin
            out_overrun_d = 1'b1;
          end
          // A low stop bit (break) must see the line return high first.
          state_d = rx ? RX_IDLE : RX_WAIT_HIGH;
        end
      end

      RX_WAIT_HIGH: begin
        if (rx) begin
          state_d = RX_IDLE;
        end
      end

      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_framed.sv
// Self-checking bench for uart_rx_framed: directed scenarios plus a random
// back-to-back stream compared against a frame-level reference model.
module tb_uart_rx_framed;

  localparam int unsigned CPB  = 4;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned DB   = 7;
  localparam int unsigned PB   = 1;
`else
  localparam int unsigned DB   = 8;
  localparam int unsigned PB   = 0;
`endif
  localparam bit          PODD = 1'b0;
  localparam int unsigned NB   = DB + PB + 1;
  // Posedge (relative to t0) at which the stop bit is sampled.
  localparam int unsigned STOP_OFS = 2 + CPB / 2 + NB * CPB;
  localparam logic [8:0]  MASK = 9'((1 << DB) - 1);

  logic          ser_clk = 1'b0;
  logic          rst_n;
  logic          SER_TX;
  logic [DB-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_frame_err;
  logic          out_parity_err;
  logic          out_overrun;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  logic          mon_en = 1'b0;
  logic [DB+1:0] act_q[$];
  logic [DB+1:0] exp_q[$];

  uart_rx_framed #(
    .clocks_per_bit (CPB),
    .data_bits      (DB),
    .parity_odd     (int'(PODD))
  ) dut (
    .ser_clk        (ser_clk),
    .rst_n          (rst_n),
    .SER_TX         (SER_TX),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_frame_err  (out_frame_err),
    .out_parity_err (out_parity_err),
    .out_overrun    (out_overrun)
  );

  always #5 ser_clk = ~ser_clk;

  always @(posedge ser_clk) cyc <= cyc + 1;

  // Each delivered word is valid for exactly one cycle while out_ready is high.
  always @(negedge ser_clk) begin
    if (mon_en && out_valid === 1'b1)
      act_q.push_back({out_parity_err, out_frame_err, out_data});
  end

  // Drive one frame starting at a negedge; t0 is the posedge at which the
  // start bit first reaches sync flop 1. Returns at a negedge, line left at stop.
  task automatic drive_frame(input logic [8:0] data, input logic par_flip,
                             input logic stop_bit, output int t0);
    logic [8:0] d;
    logic       p;
    d  = data & MASK;
    p  = (^d) ^ PODD ^ par_flip;
    t0 = cyc + 1;
    SER_TX = 1'b0;
    repeat (CPB) @(negedge ser_clk);
    for (int i = 0; i < int'(DB); i++) begin
      SER_TX = d[i];
      repeat (CPB) @(negedge ser_clk);
    end
    if (PB != 0) begin
      SER_TX = p;
      repeat (CPB) @(negedge ser_clk);
    end
    SER_TX = stop_bit;
    repeat (CPB) @(negedge ser_clk);
  endtask

  // Advance (at negedges) until cyc reaches target; bounded by the target itself.
  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge ser_clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; SER_TX = 1'b1; out_ready = 1'b1;
    repeat (3) @(negedge ser_clk);
    vectors++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_frame_err !== 1'b0 ||
        out_parity_err !== 1'b0 || out_overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%h fe=%b pe=%b ov=%b, expected all 0",
               out_valid, out_data, out_frame_err, out_parity_err, out_overrun);
    end
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge ser_clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_valid: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_basic();
    int t0;
    logic [DB-1:0] exp_d;
    exp_d = DB'(9'h0A5 & MASK);
    out_ready = 1'b1;
    drive_frame(9'h0A5, 1'b0, 1'b1, t0);
    wait_cyc(t0 + STOP_OFS - 1);
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_valid: got %b expected 0 at t0+%0d", out_valid, STOP_OFS - 1);
    end
    @(negedge ser_clk);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== exp_d) begin
      errors++;
      $display("FAIL basic_word: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, exp_d);
    end
    vectors++;
    if (out_frame_err !== 1'b0 || out_parity_err !== 1'b0 || out_overrun !== 1'b0) begin
      errors++;
      $display("FAIL basic_flags: got fe=%b pe=%b ov=%b expected 0 0 0",
               out_frame_err, out_parity_err, out_overrun);
    end
    @(negedge ser_clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse: got valid %b expected 0 one cycle later", out_valid);
    end
  endtask

  task automatic test_glitch();
    int t0;
    int seen;
    logic [DB-1:0] exp_d;
    exp_d = DB'(9'h03C & MASK);
    repeat (2 * CPB) @(negedge ser_clk);
    SER_TX = 1'b0;
    @(negedge ser_clk);
    SER_TX = 1'b1;
    seen = 0;
    repeat (4 * CPB) begin
      @(negedge ser_clk);
      if (out_valid === 1'b1) seen++;
    end
    vectors++;
    if (seen != 0) begin
      errors++;
      $display("FAIL glitch_no_word: got %0d valid cycles expected 0", seen);
    end
    drive_frame(9'h03C, 1'b0, 1'b1, t0);
    wait_cyc(t0 + STOP_OFS - 1);
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL glitch_early_valid: got %b expected 0", out_valid);
    end
    @(negedge ser_clk);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== exp_d || out_frame_err !== 1'b0) begin
      errors++;
      $display("FAIL glitch_next_frame: got v=%b d=%h fe=%b expected v=1 d=%h fe=0",
               out_valid, out_data, out_frame_err, exp_d);
    end
  endtask

  task automatic test_frame_error();
    int t0;
    int seen;
    logic [DB-1:0] exp_d;
    logic [8:0]    nxt;
    exp_d = DB'(9'h0F0 & MASK);
    repeat (2 * CPB) @(negedge ser_clk);
    drive_frame(9'h0F0, 1'b0, 1'b0, t0);
    wait_cyc(t0 + STOP_OFS);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== exp_d || out_frame_err !== 1'b1) begin
      errors++;
      $display("FAIL frame_err_word: got v=%b d=%h fe=%b expected v=1 d=%h fe=1",
               out_valid, out_data, out_frame_err, exp_d);
    end
    seen = 0;
    repeat (30) begin
      @(negedge ser_clk);
      if (out_valid === 1'b1) seen++;
    end
    vectors++;
    if (seen != 0) begin
      errors++;
      $display("FAIL frame_err_break: got %0d valid cycles while low, expected 0", seen);
    end
    SER_TX = 1'b1;
    repeat (2 * CPB) @(negedge ser_clk);
    nxt = 9'($urandom_range(0, 511)) & MASK;
    drive_frame(nxt, 1'b0, 1'b1, t0);
    wait_cyc(t0 + STOP_OFS);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== DB'(nxt) || out_frame_err !== 1'b0) begin
      errors++;
      $display("FAIL frame_err_recover: got v=%b d=%h fe=%b expected v=1 d=%h fe=0",
               out_valid, out_data, out_frame_err, DB'(nxt));
    end
    @(negedge ser_clk);
  endtask

  task automatic test_overrun();
    int t0;
    out_ready = 1'b0;
    repeat (2 * CPB) @(negedge ser_clk);
    drive_frame(9'h011, 1'b0, 1'b1, t0);
    wait_cyc(t0 + STOP_OFS);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== DB'(9'h011) || out_overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_first: got v=%b d=%h ov=%b expected v=1 d=11 ov=0",
               out_valid, out_data, out_overrun);
    end
    drive_frame(9'h022, 1'b0, 1'b1, t0);
    wait_cyc(t0 + STOP_OFS);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== DB'(9'h011) || out_overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_drop: got v=%b d=%h ov=%b expected v=1 d=11 ov=1",
               out_valid, out_data, out_overrun);
    end
    out_ready = 1'b1;
    @(negedge ser_clk);
    vectors++;
    if (out_valid !== 1'b0 || out_overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: got v=%b ov=%b expected 0 0", out_valid, out_overrun);
    end
  endtask

  task automatic test_ready_in_stop();
    int t0;
    out_ready = 1'b0;
    repeat (2 * CPB) @(negedge ser_clk);
    drive_frame(9'h011, 1'b0, 1'b1, t0);
    drive_frame(9'h022, 1'b0, 1'b1, t0);
    wait_cyc(t0 + STOP_OFS - 1);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== DB'(9'h011)) begin
      errors++;
      $display("FAIL stop_ready_pre: got v=%b d=%h expected v=1 d=11", out_valid, out_data);
    end
    out_ready = 1'b1;
    @(negedge ser_clk);
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== DB'(9'h022) || out_overrun !== 1'b0) begin
      errors++;
      $display("FAIL stop_ready_replace: got v=%b d=%h ov=%b expected v=1 d=22 ov=0",
               out_valid, out_data, out_overrun);
    end
    @(negedge ser_clk);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== DB'(9'h022)) begin
      errors++;
      $display("FAIL stop_ready_hold: got v=%b d=%h expected v=1 d=22", out_valid, out_data);
    end
    out_ready = 1'b1;
    @(negedge ser_clk);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int t0;
    out_ready = 1'b1;
    repeat (2 * CPB) @(negedge ser_clk);
    drive_frame(9'h055, 1'b1, 1'b1, t0);
    wait_cyc(t0 + STOP_OFS);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== DB'(9'h055) || out_parity_err !== 1'b1) begin
      errors++;
      $display("FAIL parity_bad: got v=%b d=%h pe=%b expected v=1 d=55 pe=1",
               out_valid, out_data, out_parity_err);
    end
    drive_frame(9'h055, 1'b0, 1'b1, t0);
    wait_cyc(t0 + STOP_OFS);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== DB'(9'h055) || out_parity_err !== 1'b0) begin
      errors++;
      $display("FAIL parity_good: got v=%b d=%h pe=%b expected v=1 d=55 pe=0",
               out_valid, out_data, out_parity_err);
    end
  endtask
`endif

  task automatic test_mid_frame_reset();
    int t0;
    logic [DB-1:0] exp_d;
    exp_d = DB'(9'h05A & MASK);
    out_ready = 1'b0;
    repeat (2 * CPB) @(negedge ser_clk);
    drive_frame(9'h077, 1'b0, 1'b1, t0);
    wait_cyc(t0 + STOP_OFS);
    // Start another frame and abort it part way through the data bits.
    SER_TX = 1'b0;
    repeat (3 * CPB) @(negedge ser_clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_overrun !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got v=%b d=%h ov=%b expected 0 0 0",
               out_valid, out_data, out_overrun);
    end
    @(negedge ser_clk);
    SER_TX = 1'b1;
    repeat (2) @(negedge ser_clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3 * CPB) @(negedge ser_clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_idle: got valid %b expected 0", out_valid);
    end
    drive_frame(9'h05A, 1'b0, 1'b1, t0);
    wait_cyc(t0 + STOP_OFS - 1);
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_early: got valid %b expected 0", out_valid);
    end
    @(negedge ser_clk);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== exp_d) begin
      errors++;
      $display("FAIL midreset_frame: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, exp_d);
    end
  endtask

  // Random stream, gaps of 0..2 idle bit-times, random stop/parity faults.
  task automatic test_back_to_back();
    int         t0;
    logic [8:0] d;
    logic       stop, flip;
    int         gap;
    out_ready = 1'b1;
    repeat (2 * CPB) @(negedge ser_clk);
    act_q.delete();
    exp_q.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      d    = 9'($urandom_range(0, 511)) & MASK;
      stop = ($urandom_range(0, 3) != 0);
      flip = (PB != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      exp_q.push_back({flip, ~stop, DB'(d)});
      drive_frame(d, flip, stop, t0);
      gap = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      SER_TX = 1'b1;
      repeat (gap * CPB) @(negedge ser_clk);
    end
    SER_TX = 1'b1;
    repeat (2 * CPB) @(negedge ser_clk);
    mon_en = 1'b0;
    vectors++;
    if (act_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_count: got %0d words expected %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      vectors++;
      if (act_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_word[%0d]: got {pe,fe,d}=%h expected %h", i, act_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (out_overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_overrun: got %b expected 0", out_overrun);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    SER_TX    = 1'b1;
    out_ready = 1'b1;
    test_reset();
    test_basic();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_ready_in_stop();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_mid_frame_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_framed.md
# uart_rx_framed

Parametrised successor to the basic serial receiver: asynchronous 8N1-style UART receive with configurable data width, mid-bit sampling, an input synchroniser, start-bit glitch rejection, stop-bit framing check and an optional parity check. Received words are presented on a valid/ready output register with overrun detection, so downstream logic (FIFO, bus bridge, debug console) can apply backpressure. Sits directly behind the `SER_TX` pad in the serial clock domain.

## Interface
- `clocks_per_bit`, 4, ser_clk cycles per bit; legal ≥ 2.
- `data_bits`, 8, data bits per frame; legal 5..9.
- `parity_odd`, 0, 0 = even, 1 = odd; used only when parity is compiled in.

- `ser_clk`  in  1  sole clock, all logic rises on posedge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `SER_TX`  in  1  serial line, asynchronous, idles high.
- `out_data`  out  data_bits  received word, LSB first on the line.
- `out_valid`  out  1  out_data holds an unconsumed word.
- `out_ready`  in  1  consumer accepts word when out_valid && out_ready.
- `out_frame_err`  out  1  held word's stop bit sampled low.
- `out_parity_err`  out  1  held word failed parity.
- `out_overrun`  out  1  sticky: a frame was dropped because the register was full.

## Operation
- Reset: all outputs 0, synchroniser flops 1, state IDLE, timers 0.
- `SER_TX` passes through a 2-flop synchroniser; FSM uses synchronised `rx`.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: `rx` low → START, timer = clocks_per_bit/2 − 1 (floor).
- Timer counts down each cycle; a sample happens in the cycle timer == 0, then timer reloads clocks_per_bit − 1.
- START sample: `rx` high → glitch, back to IDLE, nothing reported; low → DATA, bit counter = 0.
- DATA: shift `rx` in LSB-first; after data_bits samples → PARITY (compiled in) or STOP.
- PARITY: XOR of data bits and sampled bit must be 0 (even) or 1 (odd).
- STOP: sample; high → IDLE; low → frame error, go WAIT_HIGH. WAIT_HIGH → IDLE when `rx` high (prevents break re-triggering).
- On every STOP sample the word is delivered (with error flags), including framing-error words.
- Delivery: register empty, or out_ready high that cycle → load out_data/flags, out_valid = 1. Register full and out_ready low → drop the new word, set out_overrun, keep held word.
- Handshake with no simultaneous delivery clears out_valid. out_overrun clears on the next handshake.
- Timer width $clog2(clocks_per_bit); bit counter width $clog2(data_bits+1); no wrap beyond loaded values.
- rst_n asserted mid-frame aborts immediately; after release the receiver waits in IDLE and ignores a partial frame until a fresh low is seen (a line still low restarts a frame; accepted).

## Timing
- t0 = first posedge at which `SER_TX` is low at sync flop 1. IDLE sees low at t0+2.
- Start sample at t0+2+clocks_per_bit/2; stop sample at t0+2+clocks_per_bit/2+N·clocks_per_bit, N = data_bits+P+1, P = 1 if parity compiled in.
- out_valid high from the cycle after the stop sample. Defaults, no parity: posedge t0+40.
- Back-to-back frames: IDLE re-arms the cycle after the stop sample; half a stop bit of margin.

## Configuration
- `UART_RX_PARITY_EN` defined: PARITY state present, one parity bit per frame, out_parity_err driven.
- Undefined: no PARITY state, frame = start + data + stop, out_parity_err tied 0, parity_odd ignored. Port list identical either way.

## Structure
- Package `uart_pkg`: `uart_rx_state_t` enum, parity mode constants `UART_PARITY_EVEN`/`UART_PARITY_ODD`.
- Sub-module `uart_sync`: 2-flop synchroniser with reset value parameter (1 here), reusable by the transmitter loopback.

## Test plan
- Defaults, send 0xA5 8N1, out_ready high → out_valid at t0+40, out_data 0xA5, all flags 0, one-cycle pulse.
- 1-cycle low glitch on idle line → no out_valid, FSM back in IDLE, next frame 0x3C received correctly.
- Stop bit forced low, line held low 30 cycles → word delivered with out_frame_err 1; no second frame until line high.
- out_ready low, send 0x11 then 0x22 → out_data stays 0x11, out_overrun 1; raise out_ready → handshake clears both.
- out_ready pulsed in the exact stop-sample cycle of a second frame → 0x22 replaces 0x11, out_valid stays 1, no overrun.
- With UART_RX_PARITY_EN, parity_odd=0, data_bits=7: 0x55 with wrong parity → out_parity_err 1; correct parity → 0.
